// File: rtl/nabp_filter_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : nabp_filter_mapper
//  Purpose  : Turns line-buffer shift requests into filtered-projection RAM
//             reads and returns each sample one cycle later; indices outside
//             the projection read back as zero.
//  Revision : 1.0  initial release
// ============================================================================
module nabp_filter_mapper #(
    parameter int DATA_WIDTH  = 16,
    parameter int PROJ_LINES  = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int START_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mp_kick,
    input  logic [START_WIDTH-1:0] mp_start,
    input  logic                   mp_dir,
    input  logic                   mp_shift_en,
    input  logic                   mp_done,
    output logic                   fr_en,
    output logic [ADDR_WIDTH-1:0]  fr_addr,
    input  logic [DATA_WIDTH-1:0]  fr_data,
    output logic [DATA_WIDTH-1:0]  lb_val,
    output logic                   mp_busy,
    output logic                   mp_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic signed [START_WIDTH-1:0] c_proj_lines = START_WIDTH'(PROJ_LINES);
    localparam logic signed [START_WIDTH-1:0] c_one        = START_WIDTH'(1);

    state_t                        state_q, state_d;
    logic signed [START_WIDTH-1:0] idx_q, idx_d;
    logic                          dir_q, dir_d;
    logic                          rd_ok_q, rd_ok_d;
    logic                          err_q, err_d;

    logic                          in_range;
    logic                          shift_go;

    // Sign bit clear means idx >= 0; the upper bound is a signed compare.
    assign in_range = !idx_q[START_WIDTH-1] && (idx_q < c_proj_lines);

    // A kick in the same cycle swallows the shift, so no read is issued for it.
    assign shift_go = (state_q == ST_ACTIVE) && mp_shift_en && !mp_kick;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        rd_ok_d = 1'b0;
        err_d   = err_q;

        if (mp_kick) begin
            state_d = ST_ACTIVE;
            idx_d   = $signed(mp_start);
            dir_d   = mp_dir;
            if (state_q == ST_ACTIVE) begin
                err_d = 1'b1;
            end
        end else if (state_q == ST_ACTIVE) begin
            if (mp_shift_en) begin
                idx_d   = dir_q ? (idx_q - c_one) : (idx_q + c_one);
                rd_ok_d = in_range;
            end
            if (mp_done) begin
                state_d = ST_IDLE;
            end
        end else if (mp_shift_en) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            rd_ok_q <= rd_ok_d;
            err_q   <= err_d;
        end
    end

    assign fr_en   = shift_go && in_range;
    assign fr_addr = idx_q[ADDR_WIDTH-1:0];
    assign lb_val  = rd_ok_q ? fr_data : '0;
    assign mp_busy = (state_q == ST_ACTIVE);
    assign mp_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nabp_filter_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nabp_filter_mapper
//  Purpose  : Scoreboard bench: directed scenarios plus randomized runs
//             against a cycle-level reference model of the mapper.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nabp_filter_mapper;

    localparam int DATA_WIDTH  = 16;
    localparam int PROJ_LINES  = 256;
    localparam int ADDR_WIDTH  = 8;
    localparam int START_WIDTH = 10;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   mp_kick;
    logic [START_WIDTH-1:0] mp_start;
    logic                   mp_dir;
    logic                   mp_shift_en;
    logic                   mp_done;
    logic                   fr_en;
    logic [ADDR_WIDTH-1:0]  fr_addr;
    logic [DATA_WIDTH-1:0]  fr_data = '0;
    logic [DATA_WIDTH-1:0]  lb_val;
    logic                   mp_busy;
    logic                   mp_err;

    nabp_filter_mapper #(
        .DATA_WIDTH (DATA_WIDTH),
        .PROJ_LINES (PROJ_LINES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .START_WIDTH(START_WIDTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mp_kick    (mp_kick),
        .mp_start   (mp_start),
        .mp_dir     (mp_dir),
        .mp_shift_en(mp_shift_en),
        .mp_done    (mp_done),
        .fr_en      (fr_en),
        .fr_addr    (fr_addr),
        .fr_data    (fr_data),
        .lb_val     (lb_val),
        .mp_busy    (mp_busy),
        .mp_err     (mp_err)
    );

    always #5 clk = ~clk;

    // Filtered-projection RAM holding d[i] = 100 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (fr_en) fr_data <= DATA_WIDTH'(100 + int'(fr_addr));
    end

    typedef struct {
        logic        fr_en;
        int          addr;
        int          lb;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state, expressed in plain integers.
    bit m_active;
    int m_idx;
    bit m_dir;
    int m_pend;
    bit m_err;

    function automatic bit m_in_range(int i);
        return (i >= 0) && (i < PROJ_LINES);
    endfunction

    task automatic check(string name, int act, int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, want);
        end
    endtask

    // Monitor: every mid-cycle sample is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fr_en", int'(fr_en), int'(e.fr_en));
                if (e.fr_en) check("fr_addr", int'(fr_addr), e.addr);
                check("lb_val", int'(lb_val), e.lb);
                check("mp_busy", int'(mp_busy), int'(e.busy));
                check("mp_err", int'(mp_err), int'(e.err));
            end
        end
    end

    // One clock cycle: apply inputs, predict this cycle's outputs, then
    // advance the model across the next rising edge.
    task automatic cyc(bit kick, int start, bit dir, bit shift, bit done, bit rstn);
        exp_t e;
        reset_n     = rstn;
        mp_kick     = kick;
        mp_start    = START_WIDTH'(start);
        mp_dir      = dir;
        mp_shift_en = shift;
        mp_done     = done;

        e.fr_en = m_active && shift && !kick && m_in_range(m_idx);
        e.addr  = m_idx & (PROJ_LINES - 1);
        e.lb    = m_pend;
        e.busy  = m_active;
        e.err   = m_err;
        exp_q.push_back(e);

        if (!rstn) begin
            m_active = 0; m_idx = 0; m_dir = 0; m_pend = 0; m_err = 0;
        end else if (kick) begin
            if (m_active) m_err = 1;
            m_active = 1; m_idx = start; m_dir = dir; m_pend = 0;
        end else if (m_active) begin
            m_pend = 0;
            if (shift) begin
                m_pend = m_in_range(m_idx) ? 100 + m_idx : 0;
                m_idx  = m_dir ? m_idx - 1 : m_idx + 1;
            end
            if (done) m_active = 0;
        end else begin
            m_pend = 0;
            if (shift) m_err = 1;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic kick(int start, bit dir);
        cyc(1, start, dir, 0, 0, 1);
    endtask

    task automatic shifts(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 1);
    endtask

    task automatic done_cycle();
        cyc(0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start, len, r;
        reset_n = 0; mp_kick = 0; mp_start = '0; mp_dir = 0; mp_shift_en = 0; mp_done = 0;
        m_active = 0; m_idx = 0; m_dir = 0; m_pend = 0; m_err = 0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, 0);

        // Reset state holds while idle
        idle(3);
        // Ascending from 0
        kick(0, 0); shifts(4); done_cycle(); idle(1);
        // Starting below the projection
        kick(-2, 0); shifts(4); done_cycle(); idle(1);
        // Running off the top edge
        kick(254, 0); shifts(4); done_cycle(); idle(1);
        // Descending with a gap, done coincident with the last shift
        kick(1, 1); shifts(1); idle(1); shifts(1); cyc(0, 0, 0, 1, 1, 1); idle(2);
        // Shift while idle flags an error; done while idle does not
        cyc(0, 0, 0, 1, 0, 1); done_cycle(); idle(1);
        // Reset in the middle of a run
        kick(10, 0); shifts(2); cyc(0, 0, 0, 1, 0, 0); idle(2);
        // Restart kick while active
        kick(5, 0); shifts(2); kick(200, 1); shifts(3); done_cycle(); idle(1);
        cyc(0, 0, 0, 0, 0, 0);

        for (int run = 0; run < 60; run++) begin
            r     = $urandom_range(0, 9);
            start = $urandom_range(0, PROJ_LINES + 7) - 4;
            len   = $urandom_range(1, 12);
            kick(start, 1'($urandom_range(0, 1)));
            for (int i = 0; i < len; i++) begin
                if (r == 1 && i == len / 2) kick($urandom_range(0, PROJ_LINES - 1), 1'($urandom_range(0, 1)));
                else if (r == 2 && i == len / 2) cyc(0, 0, 0, 1, 0, 0);
                else cyc(0, 0, 0, 1'($urandom_range(0, 3) != 0), (i == len - 1) && (r > 5), 1);
            end
            if (r <= 5) done_cycle();
            if (r == 0) cyc(0, 0, 0, 1, 0, 1);
            idle($urandom_range(0, 2));
            if (r == 3) cyc(0, 0, 0, 0, 0, 0);
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain", exp_q.size(), 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
